x_window_reader: RTL and testbench

Consumer side of the X/F shift-register memories: on request, walks all SIZE+1 parallel taps of the X window and F window, one signed multiply-accumulate per cycle, and delivers the full-precision dot product on a valid/ready output. While it is reading, it asserts `mem_hold` so the upstream writer gates `wr_en` and the window stays frozen. It sits between the X/F tap memories and the output path of the convolution datapath.

---
 rtl/x_reader_pkg.sv | 17 +
 rtl/x_window_reader_mac_stage.sv | 31 +++
 rtl/x_window_reader.sv | 88 ++++++++
 tb/tb_x_window_reader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/x_reader_pkg.sv
// Shared types for the X/F window reader: FSM state encoding and accumulator sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package x_reader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Full product width plus enough headroom for SIZE+1 worst-case terms.
    function automatic int accw(input int width, input int logsize);
        return 2 * width + logsize + 1;
    endfunction

endpackage

// File: rtl/x_window_reader_mac_stage.sv
// Registered signed multiply-accumulate with synchronous clear (clear wins over enable).
// Latency: 1 cycle from operands to updated accumulator.
// Backpressure: none; holds its value whenever en is low.
module mac_stage #(
    parameter int WIDTH = 16,
    parameter int ACCW  = 39
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [ACCW-1:0]  acc
);

    logic signed [2*WIDTH-1:0] prod;

    assign prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACCW'(prod);
        end
    end

endmodule

// File: rtl/x_window_reader.sv
// Walks all SIZE+1 X/F taps, one MAC per cycle, and returns the dot product on valid/ready.
// Latency: SIZE+1 cycles from start handshake to y_valid.
// Backpressure: y_data held in OUT until y_ready; start_ready low outside IDLE.
module x_window_reader
    import x_reader_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SIZE    = 64,
    parameter int LOGSIZE = 6,
    parameter int ACCW    = accw(WIDTH, LOGSIZE)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [SIZE:0][WIDTH-1:0]      x_taps,
    input  logic [SIZE:0][WIDTH-1:0]      f_taps,
    input  logic                          start_valid,
    output logic                          start_ready,
    output logic                          mem_hold,
    output logic signed [ACCW-1:0]        y_data,
    output logic                          y_valid,
    input  logic                          y_ready
);

    localparam logic [LOGSIZE:0] LAST_IDX = (LOGSIZE+1)'(SIZE);
    localparam logic [LOGSIZE:0] ONE      = (LOGSIZE+1)'(1);

    state_t                    state_q;
    state_t                    state_d;
    logic [LOGSIZE:0]          idx_q;
    logic                      start_hs;
    logic                      mac_en;
    logic signed [WIDTH-1:0]   x_sel;
    logic signed [WIDTH-1:0]   f_sel;

    assign start_hs = start_valid && (state_q == IDLE);
    assign mac_en   = (state_q == ACC);
    assign x_sel    = $signed(x_taps[idx_q]);
    assign f_sel    = $signed(f_taps[idx_q]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_valid)         state_d = ACC;
            ACC:     if (idx_q == LAST_IDX)   state_d = OUT;
            OUT:     if (y_ready)             state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_comb begin
        start_ready = (state_q == IDLE);
        mem_hold    = (state_q == ACC);
        y_valid     = (state_q == OUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
        end else if (start_hs) begin
            idx_q <= '0;
        end else if (mac_en) begin
            idx_q <= idx_q + ONE;
        end
    end

    // The accumulator is frozen outside ACC, so it doubles as the held result register.
    mac_stage #(
        .WIDTH (WIDTH),
        .ACCW  (ACCW)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (start_hs),
        .en    (mac_en),
        .a     (x_sel),
        .b     (f_sel),
        .acc   (y_data)
    );

endmodule

// File: tb/tb_x_window_reader.sv
// Directed and randomized checks of x_window_reader against a plain-arithmetic dot-product model.
module tb_x_window_reader;

    localparam int WIDTH   = 16;
    localparam int SIZE    = 64;
    localparam int LOGSIZE = 6;
    localparam int ACCW    = 2 * WIDTH + LOGSIZE + 1;

    typedef logic [SIZE:0][WIDTH-1:0] win_t;

    logic                    clk = 1'b0;
    logic                    reset;
    win_t                    x_taps;
    win_t                    f_taps;
    logic                    start_valid;
    logic                    start_ready;
    logic                    mem_hold;
    logic signed [ACCW-1:0]  y_data;
    logic                    y_valid;
    logic                    y_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    x_window_reader #(
        .WIDTH   (WIDTH),
        .SIZE    (SIZE),
        .LOGSIZE (LOGSIZE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .x_taps      (x_taps),
        .f_taps      (f_taps),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .mem_hold    (mem_hold),
        .y_data      (y_data),
        .y_valid     (y_valid),
        .y_ready     (y_ready)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint dot(input win_t a, input win_t b);
        longint s = 0;
        for (int i = 0; i <= SIZE; i++) s += longint'($signed(a[i])) * longint'($signed(b[i]));
        return s;
    endfunction

    function automatic win_t fill(input int v);
        win_t w;
        logic [31:0] v32 = v;
        for (int i = 0; i <= SIZE; i++) w[i] = v32[WIDTH-1:0];
        return w;
    endfunction

    function automatic win_t ramp();
        win_t w;
        for (int i = 0; i <= SIZE; i++) w[i] = WIDTH'(i);
        return w;
    endfunction

    function automatic win_t rand_win();
        win_t w;
        for (int i = 0; i <= SIZE; i++) w[i] = WIDTH'($urandom);
        return w;
    endfunction

    // One full transaction from the IDLE state; hold = cycles y_ready stays low in OUT.
    task automatic run_one(input string tag, input win_t xv, input win_t fv, input int hold);
        longint exp_v;
        int     cyc;
        int     holds;
        exp_v  = dot(xv, fv);
        x_taps = xv;
        f_taps = fv;
        y_ready = 1'b0;
        check({tag, ".start_ready"}, 64'(start_ready), 64'(1));
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        cyc = 0;
        holds = 0;
        while (!y_valid && cyc < 200) begin
            if (mem_hold) holds++;
            cyc++;
            @(negedge clk);
        end
        check({tag, ".y_valid"}, 64'(y_valid), 64'(1));
        check({tag, ".latency"}, 64'(cyc), 64'(SIZE + 1));
        check({tag, ".hold_cycles"}, 64'(holds), 64'(SIZE + 1));
        check({tag, ".mem_hold_out"}, 64'(mem_hold), 64'(0));
        check({tag, ".y_data"}, 64'(y_data), exp_v);
        for (int k = 0; k < hold; k++) begin
            x_taps = rand_win();
            f_taps = rand_win();
            @(negedge clk);
            check({tag, ".stall_y_data"}, 64'(y_data), exp_v);
            check({tag, ".stall_y_valid"}, 64'(y_valid), 64'(1));
            check({tag, ".stall_start_ready"}, 64'(start_ready), 64'(0));
        end
        y_ready = 1'b1;
        @(negedge clk);
        y_ready = 1'b0;
        check({tag, ".done_y_valid"}, 64'(y_valid), 64'(0));
        check({tag, ".done_start_ready"}, 64'(start_ready), 64'(1));
    endtask

    initial begin
        longint exp_q[$];
        int     cyc;
        int     last;
        int     accepted;
        win_t   neg1;

        reset       = 1'b1;
        start_valid = 1'b0;
        y_ready     = 1'b0;
        x_taps      = '0;
        f_taps      = '0;
        repeat (2) @(negedge clk);
        check("rst.y_valid", 64'(y_valid), 64'(0));
        check("rst.mem_hold", 64'(mem_hold), 64'(0));
        check("rst.start_ready", 64'(start_ready), 64'(1));
        check("rst.y_data", 64'(y_data), 64'(0));
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        check("rst.ignore_start", 64'(mem_hold), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        run_one("ones", fill(1), fill(1), 0);
        run_one("ramp_pos", ramp(), fill(1), 0);
        neg1 = fill(-1);
        run_one("ramp_neg", ramp(), neg1, 0);
        run_one("min_sq", fill(-32768), fill(-32768), 10);
        for (int r = 0; r < 4; r++) run_one("random", rand_win(), rand_win(), int'($urandom_range(0, 5)));

        // Reset in the middle of accumulation, at idx 20.
        x_taps = fill(7);
        f_taps = fill(9);
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst.pre_mem_hold", 64'(mem_hold), 64'(1));
        reset = 1'b1;
        #1;
        check("midrst.y_valid", 64'(y_valid), 64'(0));
        check("midrst.mem_hold", 64'(mem_hold), 64'(0));
        check("midrst.start_ready", 64'(start_ready), 64'(1));
        check("midrst.y_data", 64'(y_data), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst.no_result", 64'(y_valid), 64'(0));
        run_one("post_rst", fill(1), fill(1), 0);

        // Continuous requests with an always-ready sink.
        start_valid = 1'b1;
        y_ready     = 1'b1;
        last        = -1;
        accepted    = 0;
        cyc         = 0;
        while (accepted < 4 && cyc < 1000) begin
            if (y_valid) begin
                if (exp_q.size() > 0) check("b2b.y_data", 64'(y_data), exp_q.pop_front());
                else check("b2b.unexpected_y_valid", 64'(y_valid), 64'(0));
            end
            if (start_ready) begin
                if (last >= 0) check("b2b.gap", 64'(cyc - last), 64'(SIZE + 3));
                last = cyc;
                accepted++;
                x_taps = rand_win();
                f_taps = rand_win();
                exp_q.push_back(dot(x_taps, f_taps));
            end
            @(negedge clk);
            cyc++;
        end
        start_valid = 1'b0;
        check("b2b.accepted", 64'(accepted), 64'(4));
        cyc = 0;
        while (!y_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b.last_y_valid", 64'(y_valid), 64'(1));
        if (exp_q.size() > 0) check("b2b.last_y_data", 64'(y_data), exp_q.pop_front());
        check("b2b.queue_empty", 64'(exp_q.size()), 64'(0));
        @(negedge clk);
        y_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
